// File: rtl/ram_pkg.sv
// Shared types and helpers for the masked
// simple dual-port RAM and its clear engine.
package ram_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  localparam int MAX_W = 1024;

  // Lane merge on max-width vectors; callers
  // size-cast in and out of their own widths.
  function automatic logic [MAX_W-1:0] lane_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_W-1:0] mask,
    input int               lw
  );
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_W; i++) begin
      if (mask[i / lw]) r[i] = new_w[i];
    end
    return r;
  endfunction

  function automatic bit cfg_ok(
    input int dw,
    input int lw,
    input int lat
  );
    return (lw > 0) && (dw <= MAX_W) &&
           (dw % lw == 0) &&
           (lat == 1 || lat == 2);
  endfunction

endpackage

// File: rtl/ram_2port_masked_if.sv
// Write/read/clear bundle of the masked
// dual-port RAM.
interface ram_2port_masked_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_WIDTH = 4,
  parameter int ADDR_WIDTH = 7
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  clr;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LANES-1:0]      wr_mask;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output clr, wr_en, wr_addr, wr_mask,
    output wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_mask,
    input  wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid
  );

endinterface

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks the array writing zero
// and owns the array write port mux.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int LANES      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  input  logic [LANES-1:0]      usr_be,
  input  logic [DATA_WIDTH-1:0] usr_din,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LANES-1:0]      mem_be,
  output logic [DATA_WIDTH-1:0] mem_din
);

  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  clr_state_t            state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CLR_RUN;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      addr_q <= addr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    busy     = 1'b0;
    mem_we   = usr_we;
    mem_addr = usr_addr;
    mem_be   = usr_be;
    mem_din  = usr_din;
    unique case (state)
      CLR_IDLE: begin
        if (clr) begin
          state_nx = CLR_RUN;
          addr_nx  = '0;
        end
      end
      CLR_RUN: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q;
        mem_be   = '1;
        mem_din  = '0;
        addr_nx  = addr_q + 1'b1;
        if (addr_q == LAST) state_nx = CLR_IDLE;
      end
      default: state_nx = CLR_IDLE;
    endcase
  end

endmodule

// File: rtl/ram_2port_masked.sv
// Simple dual-port RAM with lane masks, read
// latency 1/2, RDW policy and clear engine.
module ram_2port_masked
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANE_WIDTH = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LATENCY = 1,
  parameter int RDW_NEW    = 0
) (
  input logic              clk,
  input logic              rst,
  ram_2port_masked_if.slave bus
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (!cfg_ok(DATA_WIDTH, LANE_WIDTH, RD_LATENCY))
  begin : g_bad_cfg
    $error("ram_2port_masked: bad parameters");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  hit;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LANES-1:0]      mem_be;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_new;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_v1;
  logic [DATA_WIDTH-1:0] rd_d1;

  assign bus.busy = busy;
  assign wr_ok    = bus.wr_en & ~busy;
  assign rd_ok    = bus.rd_en & ~busy;

  ram_clear_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LANES      (LANES)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.clr),
    .busy     (busy),
    .usr_we   (wr_ok),
    .usr_addr (bus.wr_addr),
    .usr_be   (bus.wr_mask),
    .usr_din  (bus.wr_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_din  (mem_din)
  );

  // Array carries no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_be[i])
          mem[mem_addr][i*LANE_WIDTH +: LANE_WIDTH]
            <= mem_din[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  assign hit    = wr_ok & (bus.wr_addr == bus.rd_addr);
  assign rd_old = mem[bus.rd_addr];
  assign rd_new = DATA_WIDTH'(lane_merge(
                    MAX_W'(rd_old),
                    MAX_W'(bus.wr_data),
                    MAX_W'(bus.wr_mask),
                    LANE_WIDTH));
  assign rd_word = (RDW_NEW != 0 && hit) ?
                   rd_new : rd_old;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1 <= 1'b0;
      rd_d1 <= '0;
    end else begin
      rd_v1 <= rd_ok;
      if (rd_ok) rd_d1 <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  rd_v2;
    logic [DATA_WIDTH-1:0] rd_d2;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_v2 <= 1'b0;
        rd_d2 <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) rd_d2 <= rd_d1;
      end
    end

    assign bus.rd_valid = rd_v2;
    assign bus.rd_data  = rd_d2;
  end else begin : g_lat1
    assign bus.rd_valid = rd_v1;
    assign bus.rd_data  = rd_d1;
  end

endmodule
